// File: rtl/serial_signed_or_unsigned_mul.sv
// Shift-add n x n -> 2n multiplier, one product bit per clock, signed or unsigned per
// operation, with valid/ready handshakes on both the argument and the result side.
module serial_signed_or_unsigned_mul #(
  parameter int n = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           arg_vld,
  output logic           arg_rdy,
  input  logic [n-1:0]   a,
  input  logic [n-1:0]   b,
  input  logic           signed_mul,
  output logic           res_vld,
  input  logic           res_rdy,
  output logic [2*n-1:0] res
);

  localparam int cw = (n > 1) ? $clog2(n) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [cw-1:0]  cnt;
  logic [2*n-1:0] mcand;
  logic [n-1:0]   mplier;
  logic [2*n-1:0] acc;
  logic           neg;
  logic           accept;
  logic           last;
  logic [n-1:0]   a_mag;
  logic [n-1:0]   b_mag;
  logic [2*n-1:0] acc_sum;

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every combinational output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (arg_vld) state_next = BUSY;
      BUSY:    if (last)    state_next = DONE;
      DONE:    if (res_rdy) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    arg_rdy = 1'b0;
    accept  = 1'b0;
    last    = 1'b0;
    case (state)
      IDLE: begin
        arg_rdy = 1'b1;
        accept  = arg_vld;
      end
      BUSY:    last = (cnt == cw'(n - 1));
      default: ;
    endcase
  end

  // Signed mode works on magnitudes; smin maps to the unsigned value 2^(n-1).
  always_comb begin
    a_mag = (signed_mul && a[n-1]) ? (~a + n'(1)) : a;
    b_mag = (signed_mul && b[n-1]) ? (~b + n'(1)) : b;
  end

  // mcand is pre-shifted and mplier consumed LSB-first, so bit k meets mcand << k.
  assign acc_sum = acc + (mplier[0] ? mcand : '0);

  // NOTE: the datapath registers are reset too, so an operation aborted by reset
  // leaves no partial product anywhere in the block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      neg     <= 1'b0;
      res     <= '0;
      res_vld <= 1'b0;
    end else begin
      res_vld <= (state_next == DONE);
      if (accept) begin
        mcand  <= {{n{1'b0}}, a_mag};
        mplier <= b_mag;
        neg    <= signed_mul & (a[n-1] ^ b[n-1]);
        acc    <= '0;
        cnt    <= '0;
      end else if (state == BUSY) begin
        acc    <= acc_sum;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + cw'(1);
        if (last) begin
          res <= neg ? (~acc_sum + (2 * n)'(1)) : acc_sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_signed_or_unsigned_mul.sv
// Bench for serial_signed_or_unsigned_mul: directed and exhaustive n=4 vectors with
// hand-computed spot values, plus randomised n=8 and n=16 runs against an arithmetic model.
module tb_serial_signed_or_unsigned_mul;

  logic clk;
  int   total = 0;
  int   bad   = 0;
  logic rand_done [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference product by plain integer arithmetic on sign-extended operands.
  function automatic logic [63:0] ref_mul(input int w, input logic [31:0] x, input logic [31:0] y,
                                          input logic sm);
    longint sx;
    longint sy;
    longint p;
    sx = longint'(x);
    sy = longint'(y);
    if (sm && x[w-1]) sx = sx - (longint'(1) << w);
    if (sm && y[w-1]) sy = sy - (longint'(1) << w);
    p = sx * sy;
    return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  // ---------------- n = 4 instance: directed and exhaustive ----------------
  logic       rst_n4, arg_vld4, arg_rdy4, sm4, res_vld4, res_rdy4;
  logic [3:0] a4, b4;
  logic [7:0] res4;

  serial_signed_or_unsigned_mul #(.n(4)) dut4 (
    .clk        (clk),
    .rst_n      (rst_n4),
    .arg_vld    (arg_vld4),
    .arg_rdy    (arg_rdy4),
    .a          (a4),
    .b          (b4),
    .signed_mul (sm4),
    .res_vld    (res_vld4),
    .res_rdy    (res_rdy4),
    .res        (res4)
  );

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic start4(input logic [3:0] ta, input logic [3:0] tb, input logic tsm);
    int t;
    t = 0;
    a4 = ta;
    b4 = tb;
    sm4 = tsm;
    arg_vld4 = 1'b1;
    while (!arg_rdy4 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("n4 accept rdy", 64'(arg_rdy4), 64'd1);
    @(negedge clk);
    arg_vld4 = 1'b0;
  endtask

  task automatic wait4(output int lat, output logic leak);
    lat = 0;
    leak = 1'b0;
    while (!res_vld4 && lat < 40) begin
      if (arg_rdy4) leak = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (arg_rdy4) leak = 1'b1;
    check("n4 res_vld", 64'(res_vld4), 64'd1);
  endtask

  task automatic take4();
    res_rdy4 = 1'b1;
    @(negedge clk);
    res_rdy4 = 1'b0;
  endtask

  task automatic run4(input logic [3:0] ta, input logic [3:0] tb, input logic tsm,
                      output logic [7:0] r, output int lat, output logic leak);
    start4(ta, tb, tsm);
    wait4(lat, leak);
    r = res4;
    take4();
  endtask

  // ---------------- n = 8 / n = 16 instances: randomised ----------------
  for (genvar g = 0; g < 2; g++) begin : g_rand
    localparam int W    = (g == 0) ? 8 : 16;
    localparam int NOPS = (g == 0) ? 150 : 80;

    logic           rst_n, arg_vld, arg_rdy, sm, res_vld, res_rdy;
    logic [W-1:0]   a, b;
    logic [2*W-1:0] res;

    serial_signed_or_unsigned_mul #(.n(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .arg_vld    (arg_vld),
      .arg_rdy    (arg_rdy),
      .a          (a),
      .b          (b),
      .signed_mul (sm),
      .res_vld    (res_vld),
      .res_rdy    (res_rdy),
      .res        (res)
    );

    initial begin
      int          t;
      int          lat;
      int          gap;
      logic [63:0] exp;
      string       tag;
      rand_done[g] = 1'b0;
      rst_n = 1'b0;
      arg_vld = 1'b0;
      res_rdy = 1'b0;
      a = '0;
      b = '0;
      sm = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < NOPS; k++) begin
        gap = $urandom_range(0, 3);
        repeat (gap) @(negedge clk);
        case (k)
          0:       begin a = {1'b1, {(W-1){1'b0}}}; b = {1'b1, {(W-1){1'b0}}}; sm = 1'b1; end
          1:       begin a = '1; b = '1; sm = 1'b0; end
          2:       begin a = '1; b = '1; sm = 1'b1; end
          3:       begin a = '0; b = {1'b1, {(W-1){1'b0}}}; sm = 1'b1; end
          default: begin a = W'($urandom()); b = W'($urandom()); sm = 1'($urandom_range(0, 1)); end
        endcase
        exp = ref_mul(W, 32'(a), 32'(b), sm);
        tag = $sformatf("n%0d op%0d %0h*%0h s%0d", W, k, a, b, sm);
        arg_vld = 1'b1;
        t = 0;
        while (!arg_rdy && t < 50) begin
          @(negedge clk);
          t++;
        end
        check({tag, " rdy"}, 64'(arg_rdy), 64'd1);
        @(negedge clk);
        lat = 0;
        while (!res_vld && lat < 4 * W) begin
          arg_vld = 1'($urandom_range(0, 1));
          a = W'($urandom());
          b = W'($urandom());
          sm = 1'($urandom_range(0, 1));
          @(negedge clk);
          lat++;
        end
        check({tag, " vld"}, 64'(res_vld), 64'd1);
        check({tag, " lat"}, 64'(lat), 64'(W));
        gap = $urandom_range(0, 3);
        repeat (gap) begin
          arg_vld = 1'($urandom_range(0, 1));
          @(negedge clk);
        end
        arg_vld = 1'b0;
        check({tag, " res"}, 64'(res), exp);
        res_rdy = 1'b1;
        @(negedge clk);
        res_rdy = 1'b0;
        check({tag, " drop"}, 64'(res_vld), 64'd0);
      end
      rand_done[g] = 1'b1;
    end
  end

  // ---------------- main directed sequence ----------------
  initial begin
    logic [7:0] r;
    logic [7:0] hold;
    int         lat;
    int         t;
    logic       leak;
    rst_n4 = 1'b0;
    arg_vld4 = 1'b0;
    res_rdy4 = 1'b0;
    a4 = '0;
    b4 = '0;
    sm4 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst res_vld", 64'(res_vld4), 64'd0);
    check("rst res", 64'(res4), 64'd0);
    rst_n4 = 1'b1;
    @(negedge clk);
    check("post rst arg_rdy", 64'(arg_rdy4), 64'd1);

    // Hand-computed spot checks.
    run4(4'hF, 4'hF, 1'b0, r, lat, leak);
    check("u 15*15", 64'(r), 64'hE1);
    check("u 15*15 lat", 64'(lat), 64'd4);
    check("u 15*15 rdy low", 64'(leak), 64'd0);
    run4(4'hF, 4'hF, 1'b1, r, lat, leak);
    check("s -1*-1 back2back", 64'(r), 64'h01);
    run4(4'h8, 4'h8, 1'b1, r, lat, leak);
    check("s -8*-8", 64'(r), 64'h40);
    check("s -8*-8 lat", 64'(lat), 64'd4);
    run4(4'h8, 4'h7, 1'b1, r, lat, leak);
    check("s -8*7", 64'(r), 64'hC8);
    run4(4'h7, 4'hF, 1'b1, r, lat, leak);
    check("s 7*-1", 64'(r), 64'hF9);
    run4(4'h0, 4'hF, 1'b1, r, lat, leak);
    check("s 0*-1", 64'(r), 64'h00);

    // Exhaustive, both modes.
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 16; i++) begin
        for (int j = 0; j < 16; j++) begin
          run4(4'(i), 4'(j), 1'(s), r, lat, leak);
          check($sformatf("x s%0d %0d*%0d", s, i, j), 64'(r),
                ref_mul(4, 32'(i), 32'(j), 1'(s)));
        end
      end
    end

    // Back-pressure: result must hold while inputs wander.
    start4(4'h6, 4'h5, 1'b0);
    wait4(lat, leak);
    hold = res4;
    check("bp res", 64'(hold), 64'h1E);
    repeat (5) begin
      a4 = 4'($urandom());
      b4 = 4'($urandom());
      sm4 = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("bp vld hold", 64'(res_vld4), 64'd1);
      check("bp res hold", 64'(res4), 64'h1E);
      check("bp arg_rdy", 64'(arg_rdy4), 64'd0);
    end
    take4();
    check("bp release vld", 64'(res_vld4), 64'd0);
    check("bp release rdy", 64'(arg_rdy4), 64'd1);
    check("bp res kept", 64'(res4), 64'h1E);

    // Reset on the second BUSY cycle, then a fresh operation.
    start4(4'h9, 4'h7, 1'b1);
    @(negedge clk);
    rst_n4 = 1'b0;
    @(negedge clk);
    check("mid rst res_vld", 64'(res_vld4), 64'd0);
    check("mid rst res", 64'(res4), 64'd0);
    check("mid rst arg_rdy", 64'(arg_rdy4), 64'd1);
    rst_n4 = 1'b1;
    @(negedge clk);
    check("mid rst release rdy", 64'(arg_rdy4), 64'd1);
    run4(4'h3, 4'h5, 1'b0, r, lat, leak);
    check("after rst 3*5", 64'(r), 64'h0F);
    check("after rst lat", 64'(lat), 64'd4);

    t = 0;
    while (!(rand_done[0] && rand_done[1]) && t < 60000) begin
      @(negedge clk);
      t++;
    end
    check("rand runs finished", 64'({rand_done[0], rand_done[1]}), 64'd3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
